// File: rtl/udp_tx_packetizer.sv
// Buffers one framed 32-bit word packet, then hands it to the UDP transmitter on tx_req.
// Optional UDP_PKT_TIMEOUT_EN adds a stall timeout while serving the transmitter.
module udp_tx_packetizer #(
  parameter int DEPTH_WORDS    = 256,
  parameter int ADDR_W         = 8,
  parameter int IFG_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_keep,
  input  logic [47:0] in_des_mac,
  input  logic [31:0] in_des_ip,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        err_pulse
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DROP, S_START, S_SEND, S_WAIT, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     wcnt_q, wcnt_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]         gap_cnt_q, gap_cnt_d;
  logic                ovr_req_q, ovr_req_d;
  logic                in_ready_q, in_ready_d;
  logic                tx_start_en_q, tx_start_en_d;
  logic [15:0]         tx_byte_num_q, tx_byte_num_d;
  logic [47:0]         des_mac_q, des_mac_d;
  logic [31:0]         des_ip_q, des_ip_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [31:0]         tx_data_q;
  logic                wr_en, rd_en, accept;
  logic [2:0]          keep_bytes;
`ifdef UDP_PKT_TIMEOUT_EN
  logic [15:0]         to_cnt_q, to_cnt_d;
`endif

  logic [31:0] mem [DEPTH_WORDS];

  assign accept     = in_valid && in_ready_q;
  assign keep_bytes = (in_keep == 2'd0) ? 3'd4 : {1'b0, in_keep};

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    wcnt_d        = wcnt_q;
    rd_ptr_d      = rd_ptr_q;
    gap_cnt_d     = gap_cnt_q;
    ovr_req_d     = ovr_req_q;
    tx_byte_num_d = tx_byte_num_q;
    des_mac_d     = des_mac_q;
    des_ip_d      = des_ip_q;
    err_d         = 1'b0;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
`ifdef UDP_PKT_TIMEOUT_EN
    to_cnt_d      = 16'd0;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        wr_en     = 1'b1;
        des_mac_d = in_des_mac;
        des_ip_d  = in_des_ip;
        if (in_last) begin
          tx_byte_num_d = 16'(keep_bytes);
          wcnt_d        = (ADDR_W+1)'(1);
          state_d       = S_START;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          state_d  = S_FILL;
        end
      end
      S_FILL: if (accept) begin
        wr_en = 1'b1;
        if (in_last) begin
          tx_byte_num_d = 16'({wr_ptr_q, 2'b00}) + 16'(keep_bytes);
          wcnt_d        = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
          state_d       = S_START;
        end else if (wr_ptr_q == ADDR_W'(DEPTH_WORDS-1)) begin
          // Buffer full without a last: close the packet on whole words, swallow the rest.
          tx_byte_num_d = 16'(DEPTH_WORDS*4);
          wcnt_d        = (ADDR_W+1)'(DEPTH_WORDS);
          err_d         = 1'b1;
          state_d       = S_DROP;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
      end
      S_DROP: if (accept && in_last) state_d = S_START;
      S_START: begin
        rd_ptr_d  = '0;
        ovr_req_d = 1'b0;
        state_d   = S_SEND;
      end
      S_SEND, S_WAIT: begin
        if (tx_done) begin
          gap_cnt_d = 16'd0;
          state_d   = S_GAP;
        end else if (tx_req) begin
          if (rd_ptr_q < wcnt_q) begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
            if (rd_ptr_d == wcnt_q) state_d = S_WAIT;
          end else if (!ovr_req_q) begin
            ovr_req_d = 1'b1;
            err_d     = 1'b1;
          end
        end
`ifdef UDP_PKT_TIMEOUT_EN
        if (!tx_done && !tx_req) begin
          if (to_cnt_q == 16'(TIMEOUT_CYCLES-1)) begin
            gap_cnt_d = 16'd0;
            err_d     = 1'b1;
            state_d   = S_GAP;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt_q == 16'(IFG_CYCLES-1)) begin
          wr_ptr_d = '0;
          state_d  = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d    = (state_d == S_IDLE) || (state_d == S_FILL) || (state_d == S_DROP);
    busy_d        = (state_d != S_IDLE);
    tx_start_en_d = (state_d == S_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      wcnt_q        <= '0;
      rd_ptr_q      <= '0;
      gap_cnt_q     <= '0;
      ovr_req_q     <= 1'b0;
      in_ready_q    <= 1'b1;
      tx_start_en_q <= 1'b0;
      tx_byte_num_q <= '0;
      des_mac_q     <= '0;
      des_ip_q      <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wcnt_q        <= wcnt_d;
      rd_ptr_q      <= rd_ptr_d;
      gap_cnt_q     <= gap_cnt_d;
      ovr_req_q     <= ovr_req_d;
      in_ready_q    <= in_ready_d;
      tx_start_en_q <= tx_start_en_d;
      tx_byte_num_q <= tx_byte_num_d;
      des_mac_q     <= des_mac_d;
      des_ip_q      <= des_ip_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

`ifdef UDP_PKT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
  end

  // Synchronous read: data lands the cycle after tx_req is sampled and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tx_data_q <= '0;
    else if (rd_en) tx_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  assign in_ready    = in_ready_q;
  assign tx_start_en = tx_start_en_q;
  assign tx_byte_num = tx_byte_num_q;
  assign des_mac     = des_mac_q;
  assign des_ip      = des_ip_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign err_pulse   = err_q;

endmodule

// File: doc/udp_tx_packetizer.md
Name: udp_tx_packetizer

Overview:
- User-side feeder for the UDP transmit path. Accepts a 32-bit word stream with packet framing and buffers one packet in on-chip RAM.
- Once the packet is complete, issues the transmit start, byte count and destination to the UDP transmitter. Serves the packet's words back in response to the transmitter's tx_req.
- Sits in the gmii_tx_clk domain, between the application and the UDP transmitter's tx_start_en/tx_data/tx_byte_num/tx_req/tx_done interface.

Parameters:
- DEPTH_WORDS, 256, packet buffer depth in 32-bit words; also the maximum packet length.
- ADDR_W, 8, buffer address width; must satisfy 2^ADDR_W = DEPTH_WORDS.
- IFG_CYCLES, 16, minimum idle cycles between tx_done and the next tx_start_en.
- TIMEOUT_CYCLES, 65535, cycles allowed in WAIT_DONE before abort (optional feature only).

Ports:
- clk  in  1  transmit clock (gmii_tx_clk domain).
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  32  input word; first byte in [31:24].
- in_last  in  1  qualifies the final word of a packet.
- in_keep  in  2  valid bytes in the last word (0 means 4); ignored when in_last=0.
- in_des_mac  in  48  destination MAC, sampled with the first word of a packet.
- in_des_ip  in  32  destination IP, sampled with the first word of a packet.
- tx_start_en  out  1  one-cycle start pulse to the transmitter.
- tx_byte_num  out  16  packet length in bytes; stable from start until tx_done.
- des_mac  out  48  latched destination MAC.
- des_ip  out  32  latched destination IP.
- tx_req  in  1  transmitter requests the next word.
- tx_data  out  32  word served to the transmitter.
- tx_done  in  1  transmitter finished the frame.
- busy  out  1  high in every state except IDLE.
- err_pulse  out  1  one-cycle error strobe.

Behaviour:
- Reset values: all outputs 0; in_ready=1; FSM in IDLE; write and read pointers 0.
- A word is accepted only on cycles where in_valid and in_ready are both 1.
- IDLE: accepting a word writes it to buffer[0] and latches des_mac/des_ip. If in_last=1 go to START, else go to FILL.
- FILL: each accepted word is written at wr_ptr and wr_ptr increments.
  - in_last on an accepted word goes to START.
  - Accepting word number DEPTH_WORDS without in_last forces an end of packet. The byte count is full words only (DEPTH_WORDS*4), err_pulse fires, and any further words until in_last are dropped with in_ready held 1.
  - Dropped words are never written to the buffer.
- Byte count (registered): tx_byte_num = (words-1)*4 + (in_keep==0 ? 4 : in_keep). The result is 16 bits; with the default depth the maximum is 1024.
- START: in_ready=0; tx_start_en=1 for exactly one cycle; rd_ptr=0; the FSM moves to SEND on the next cycle.
- SEND: on each cycle with tx_req=1, tx_data <= buffer[rd_ptr] and rd_ptr increments.
  - Synchronous RAM read: tx_data is valid on the cycle after tx_req is sampled.
  - Once rd_ptr reaches the word count, further tx_req cycles hold tx_data at its last value and raise err_pulse once.
  - A tx_done seen in SEND or WAIT_DONE goes to GAP.
  - SEND moves to WAIT_DONE after the last word has been served.
- GAP: counts IFG_CYCLES, then returns to IDLE with in_ready=1.
- in_ready is 1 only in IDLE, in FILL, and while dropping overflow words.
- A tx_done arriving in IDLE or FILL is ignored.
- A tx_req arriving outside SEND/WAIT_DONE is ignored; tx_data is unchanged.
- Reset asserted mid-packet returns everything to reset values immediately; the partial packet is discarded.
- tx_byte_num, des_mac and des_ip are stable from tx_start_en until GAP is left.

Optional Feature:
- Macro: UDP_PKT_TIMEOUT_EN.
- When defined: a 16-bit counter runs in SEND and WAIT_DONE and clears on every tx_req or tx_done. If it reaches TIMEOUT_CYCLES, the FSM goes to GAP and err_pulse fires.
- When undefined: there is no counter, and the FSM waits for tx_done indefinitely.

Test Plan:
- Send 3 words 0x11223344, 0x55667788, 0x99AABBCC with in_last on the 3rd and in_keep=2 -> one tx_start_en pulse; tx_byte_num=10; words returned in order, each one cycle after its tx_req; busy stays 1 until IFG_CYCLES after tx_done.
- Single-word packet with in_last=1, in_keep=0 -> tx_byte_num=4; FILL is skipped; des_mac/des_ip equal the values presented with that word.
- Send 257 words with no in_last, then in_last -> tx_byte_num=1024; one err_pulse at overflow; 256 words sent, and the 257th is never written to the buffer.
- After a 2-word packet is served, assert tx_req 2 extra cycles -> tx_data holds word 1; exactly one err_pulse.
- Assert rst_n=0 during FILL after 5 words -> all outputs return to reset values; a following 1-word packet gives tx_byte_num=4.
- With UDP_PKT_TIMEOUT_EN and TIMEOUT_CYCLES=100, never assert tx_done -> after 100 idle cycles the FSM enters GAP, err_pulse fires, then the block returns to IDLE.
